pluto_spi_frame_ctrl: RTL and testbench

- Frame-level controller between the byte-level SPI shifter and the PWM/digital-output datapath.
- Collects host bytes into shadow registers and validates each SSEL frame (length plus XOR checksum).
- Commits all shadow words to the active registers atomically at frame end, never mid-frame.
- Runs a communication watchdog that forces the PWM outputs to a safe value when the host stops sending valid frames.

---
 rtl/pluto_spi_frame_ctrl_pkg.sv | 22 ++
 rtl/pluto_spi_frame_ctrl_wdt.sv | 36 +++
 rtl/pluto_spi_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_pluto_spi_frame_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pluto_spi_frame_ctrl_pkg.sv
// Shared types and constants for the SPI frame controller.
package pluto_spi_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Word indices inside reg_q
  localparam int unsigned PWM0 = 0;
  localparam int unsigned PWM1 = 1;
  localparam int unsigned PWM2 = 2;
  localparam int unsigned PWM3 = 3;
  localparam int unsigned CTRL = 4;

  localparam int unsigned NBYTES_DEFAULT = 20;

  // Value forced onto the PWM words when the host goes silent
  localparam logic [15:0] SAFE_PWM = 16'h0000;

endpackage

// File: rtl/pluto_spi_frame_ctrl_wdt.sv
// Communication watchdog: counts while armed, trips at the limit, sticky until cleared.
module pluto_spi_wdt #(
  parameter int unsigned WDT_W     = 20,
  parameter int unsigned WDT_LIMIT = 400000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_expire,
  output logic o_trip
);

  logic [WDT_W-1:0] r_cnt;
  logic             r_trip;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == WDT_W'(WDT_LIMIT - 1));
  // A clear on the same edge as expiry wins, so no expire pulse is reported
  assign o_expire   = !r_trip && w_at_limit && !i_clear;
  assign o_trip     = r_trip;

  // Counter and sticky trip flag; trip starts set so outputs stay safe until the first commit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_trip <= 1'b1;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_trip <= 1'b0;
    end else if (!r_trip) begin
      if (w_at_limit) r_trip <= 1'b1;
      else            r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pluto_spi_frame_ctrl.sv
// Frame-level SPI controller: shadow capture, frame validation, atomic commit, watchdog.
module pluto_spi_frame_ctrl
  import pluto_spi_frame_ctrl_pkg::*;
#(
  parameter int unsigned NREG      = 5,
  parameter int unsigned NBYTES    = NBYTES_DEFAULT,
  parameter int unsigned WDT_W     = 20,
  parameter int unsigned WDT_LIMIT = 400000
) (
  input  logic                clk,
  input  logic                nRESET,
  input  logic                ssel_start,
  input  logic                ssel_end,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic [4:0]          byte_idx,
  output logic [16*NREG-1:0]  reg_q,
  output logic                commit,
  output logic                frame_err,
  output logic [7:0]          err_cnt,
  output logic                wdt_trip
);

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_byte_idx;
  logic [7:0]  r_chk, r_rx_chk;
  logic        r_ovr;
  logic [15:0] r_shadow [NREG];
  logic [15:0] r_active [NREG];
  logic        r_commit, r_frame_err;
  logic [7:0]  r_err_cnt;

  logic        w_take, w_commit_now, w_reject_now, w_frame_ok;
  logic [4:0]  w_idx_base;
  logic [7:0]  w_chk_base;
  logic        w_wdt_expire, w_wdt_trip;

  // A start pulse in any state begins a fresh frame, so the byte seen with it is index 0
  assign w_idx_base = ssel_start ? '0 : r_byte_idx;
  assign w_chk_base = ssel_start ? '0 : r_chk;

  // State register
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and frame decision strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_take       = 1'b0;
    w_commit_now = 1'b0;
    w_reject_now = 1'b0;
    w_frame_ok   = (32'(r_byte_idx) == NBYTES) && !r_ovr && (r_chk == r_rx_chk);
    unique case (r_state)
      ST_IDLE: begin
        if (ssel_start) begin
          w_state_nxt = ST_RECV;
          w_take      = byte_valid;
        end
      end
      ST_RECV: begin
        w_take = byte_valid;
        if (ssel_start) begin
          w_reject_now = 1'b1;
        end else if (ssel_end) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_commit_now = w_frame_ok;
        w_reject_now = !w_frame_ok;
        w_take       = ssel_start && byte_valid;
        w_state_nxt  = ssel_start ? ST_RECV : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Byte counter, running checksum, overrun flag and shadow capture
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_byte_idx <= '0;
      r_chk      <= '0;
      r_rx_chk   <= '0;
      r_ovr      <= 1'b0;
      for (int unsigned k = 0; k < NREG; k++) r_shadow[k] <= '0;
    end else begin
      if (ssel_start) begin
        r_byte_idx <= '0;
        r_chk      <= '0;
        r_ovr      <= 1'b0;
      end
      if (w_take) begin
        if (w_idx_base != '1) r_byte_idx <= w_idx_base + 5'd1;
        if (32'(w_idx_base) < NBYTES - 1)       r_chk    <= w_chk_base ^ byte_data;
        else if (32'(w_idx_base) == NBYTES - 1) r_rx_chk <= byte_data;
        else                                    r_ovr    <= 1'b1;
        for (int unsigned k = 0; k < NREG; k++) begin
          if (32'(w_idx_base) == 2*k)          r_shadow[k][7:0]  <= byte_data;
          else if (32'(w_idx_base) == 2*k + 1) r_shadow[k][15:8] <= byte_data;
        end
      end
    end
  end

  // Active registers, result pulses and saturating error counter
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      for (int unsigned k = 0; k < NREG; k++) r_active[k] <= '0;
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_commit    <= w_commit_now;
      r_frame_err <= w_reject_now;
      if (w_reject_now && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_commit_now) begin
        for (int unsigned k = 0; k < NREG; k++) r_active[k] <= r_shadow[k];
      end else if (w_wdt_expire) begin
        for (int unsigned k = PWM0; k <= PWM3; k++)
          if (k < NREG) r_active[k] <= SAFE_PWM;
      end
    end
  end

  // Flatten active words onto the output bus
  always_comb begin
    reg_q = '0;
    for (int unsigned k = 0; k < NREG; k++) reg_q[16*k +: 16] = r_active[k];
  end

  pluto_spi_wdt #(
    .WDT_W     (WDT_W),
    .WDT_LIMIT (WDT_LIMIT)
  ) u_wdt (
    .i_clk    (clk),
    .i_rst_n  (nRESET),
    .i_clear  (w_commit_now),
    .o_expire (w_wdt_expire),
    .o_trip   (w_wdt_trip)
  );

  assign byte_idx  = r_byte_idx;
  assign commit    = r_commit;
  assign frame_err = r_frame_err;
  assign err_cnt   = r_err_cnt;
  assign wdt_trip  = w_wdt_trip;

endmodule

// File: tb/tb_pluto_spi_frame_ctrl.sv
// Scoreboard bench for pluto_spi_frame_ctrl with a short watchdog period.
module tb_pluto_spi_frame_ctrl;

  localparam int unsigned NREG = 5;
  localparam logic [79:0] Q_A      = 80'h0000_0000_0000_0000_8400;
  localparam logic [79:0] Q_B      = 80'h0003_0000_0000_0000_8400;
  localparam logic [79:0] Q_B_SAFE = 80'h0003_0000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        nRESET;
  logic        ssel_start, ssel_end, byte_valid;
  logic [7:0]  byte_data;
  logic [4:0]  byte_idx;
  logic [79:0] reg_q;
  logic        commit, frame_err, wdt_trip;
  logic [7:0]  err_cnt;

  typedef struct {
    logic        is_commit;
    logic [79:0] q;
    logic [7:0]  ec;
    logic        trip;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [7:0]  frm [32];
  int          nchk = 0;
  int          nfail = 0;

  pluto_spi_frame_ctrl #(
    .NREG      (NREG),
    .NBYTES    (20),
    .WDT_W     (20),
    .WDT_LIMIT (100)
  ) dut (
    .clk        (clk),
    .nRESET     (nRESET),
    .ssel_start (ssel_start),
    .ssel_end   (ssel_end),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_idx   (byte_idx),
    .reg_q      (reg_q),
    .commit     (commit),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt),
    .wdt_trip   (wdt_trip)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every commit/frame_err pulse is matched against the next expected event
  always @(negedge clk) begin
    if (commit || frame_err) begin
      if (sb.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_event: commit=%0b frame_err=%0b required no event", commit, frame_err);
      end else begin
        e = sb.pop_front();
        check("event_kind", 80'({commit, frame_err}), 80'({e.is_commit, !e.is_commit}));
        check("event_reg_q", reg_q, e.q);
        check("event_err_cnt", 80'(err_cnt), 80'(e.ec));
        check("event_wdt_trip", 80'(wdt_trip), 80'(e.trip));
      end
    end
  end

  task automatic push(input logic is_c, input logic [79:0] q, input logic [7:0] ec, input logic trip);
    exp_t x;
    x.is_commit = is_c;
    x.q = q;
    x.ec = ec;
    x.trip = trip;
    sb.push_back(x);
  endtask

  task automatic set_frame(input logic [7:0] b1, input logic [7:0] b8, input logic [7:0] c);
    for (int i = 0; i < 32; i++) frm[i] = 8'h00;
    frm[1] = b1;
    frm[8] = b8;
    frm[19] = c;
  endtask

  task automatic send(input int n, input bit do_start, input bit start_on_first,
                      input bit do_end, input bit end_on_last);
    @(posedge clk); #1;
    if (do_start && !start_on_first) begin
      ssel_start = 1'b1;
      @(posedge clk); #1;
      ssel_start = 1'b0;
      @(posedge clk); #1;
    end
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      byte_data  = frm[i];
      if (i == 0 && do_start && start_on_first) ssel_start = 1'b1;
      if (i == n - 1 && do_end && end_on_last) ssel_end = 1'b1;
      @(posedge clk); #1;
      byte_valid = 1'b0;
      ssel_start = 1'b0;
      ssel_end   = 1'b0;
      @(posedge clk); #1;
    end
    if (do_end && !end_on_last) begin
      ssel_end = 1'b1;
      @(posedge clk); #1;
      ssel_end = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    check(name, 80'(sb.size()), 80'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_reg_q"}, reg_q, 80'h0);
    check({tag, "_commit"}, 80'(commit), 80'(0));
    check({tag, "_frame_err"}, 80'(frame_err), 80'(0));
    check({tag, "_err_cnt"}, 80'(err_cnt), 80'(0));
    check({tag, "_byte_idx"}, 80'(byte_idx), 80'(0));
    check({tag, "_wdt_trip"}, 80'(wdt_trip), 80'(1));
  endtask

  initial begin
    int n;
    nRESET = 1'b0; ssel_start = 1'b0; ssel_end = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 nRESET = 1'b1;
    #1 check_reset_values("reset");

    // Valid frame A
    set_frame(8'h84, 8'h00, 8'h84);
    push(1'b1, Q_A, 8'd0, 1'b0);
    send(20, 1, 0, 1, 0);
    wait_drain("drain_valid_a");

    // Let the watchdog expire so later rejections see a stable safe state
    repeat (120) @(posedge clk);
    #1 check("trip_after_idle", 80'(wdt_trip), 80'(1));
    check("safe_reg_q", reg_q, 80'h0);

    // Bad checksum
    set_frame(8'h84, 8'h00, 8'h85);
    push(1'b0, 80'h0, 8'd1, 1'b1);
    send(20, 1, 0, 1, 0);
    wait_drain("drain_bad_chk");

    // Short frame (19 bytes)
    set_frame(8'h84, 8'h00, 8'h84);
    push(1'b0, 80'h0, 8'd2, 1'b1);
    send(19, 1, 0, 1, 0);
    wait_drain("drain_short");

    // Overrun (21 bytes)
    push(1'b0, 80'h0, 8'd3, 1'b1);
    send(21, 1, 0, 1, 0);
    wait_drain("drain_overrun");

    // Frame B, then measure watchdog latency from commit
    set_frame(8'h84, 8'h03, 8'h87);
    push(1'b1, Q_B, 8'd3, 1'b0);
    send(20, 1, 0, 1, 0);
    for (int i = 0; i < 20 && !commit; i++) @(negedge clk);
    check("commit_b_seen", 80'(commit), 80'(1));
    n = 0;
    while (!wdt_trip && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wdt_latency", 80'(n), 80'(100));
    check("wdt_safe_reg_q", reg_q, Q_B_SAFE);
    wait_drain("drain_valid_b");

    // Next valid frame clears the trip
    set_frame(8'h84, 8'h00, 8'h84);
    push(1'b1, Q_A, 8'd3, 1'b0);
    send(20, 1, 0, 1, 0);
    wait_drain("drain_recover");
    check("trip_cleared", 80'(wdt_trip), 80'(0));

    // Missed ssel_end: second start (with byte 0) rejects the partial frame
    for (int i = 0; i < 32; i++) frm[i] = 8'h00;
    frm[0] = 8'h11; frm[1] = 8'h22; frm[2] = 8'h33;
    push(1'b0, Q_A, 8'd4, 1'b0);
    send(3, 1, 0, 0, 0);
    check("partial_byte_idx", 80'(byte_idx), 80'(3));
    set_frame(8'h84, 8'h03, 8'h87);
    push(1'b1, Q_B, 8'd4, 1'b0);
    send(20, 1, 1, 1, 1);
    wait_drain("drain_restart");

    // Asynchronous reset in the middle of a frame
    set_frame(8'h84, 8'h00, 8'h84);
    send(7, 1, 0, 0, 0);
    check("pre_reset_byte_idx", 80'(byte_idx), 80'(7));
    nRESET = 1'b0;
    #2 check_reset_values("midreset");
    @(posedge clk); @(posedge clk);
    #1 nRESET = 1'b1;
    push(1'b1, Q_A, 8'd0, 1'b0);
    send(20, 1, 0, 1, 0);
    wait_drain("drain_after_reset");

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 80'(sb.size()), 80'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
